// File: rtl/iob_cache_axi_read_responder_pkg.sv
// Shared encodings for the AXI4 read responder: burst types, response codes and FSM states.
package iob_cache_axi_read_responder_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // A WRAP burst must cover 2, 4, 8 or 16 beats to define a legal wrap boundary.
    function automatic logic wrapLenOk(input int unsigned len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

endpackage

// File: rtl/iob_cache_axi_read_skid.sv
// Two-entry fall-through FIFO holding {rdata, rresp, rlast} between the memory and the R channel.
module iob_cache_axi_read_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [1:0]        push_resp_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        resp_o,
    output logic              last_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] r_data [2];
    logic [1:0]        r_resp [2];
    logic              r_last [2];
    logic              r_rdPtr;
    logic              r_wrPtr;
    logic [1:0]        r_count;

    logic w_empty;
    logic w_store;
    logic w_release;

    // An empty FIFO presents the incoming beat directly, so a beat can leave the cycle it arrives.
    assign w_empty   = (r_count == 2'd0);
    assign valid_o   = ~w_empty | push_i;
    assign data_o    = w_empty ? push_data_i : r_data[r_rdPtr];
    assign resp_o    = w_empty ? push_resp_i : r_resp[r_rdPtr];
    assign last_o    = w_empty ? push_last_i : r_last[r_rdPtr];
    assign count_o   = r_count;

    assign w_release = pop_i & ~w_empty;
    assign w_store   = push_i & ~(w_empty & pop_i);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_store) begin
                r_data[r_wrPtr] <= push_data_i;
                r_resp[r_wrPtr] <= push_resp_i;
                r_last[r_wrPtr] <= push_last_i;
                r_wrPtr         <= ~r_wrPtr;
            end
            if (w_release) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_release};
        end
    end

endmodule

// File: rtl/iob_cache_axi_read_responder.sv
// AXI4 read-channel responder serving one AR burst at a time from a 1-cycle-latency memory.
// Define IOB_CACHE_AXI_READ_WRAP_EN for true WRAP bursts; otherwise WRAP behaves as INCR.
module iob_cache_axi_read_responder
    import iob_cache_axi_read_responder_pkg::*;
#(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 10,
    parameter int NBYTES_W   = $clog2(AXI_DATA_W / 8)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [AXI_ID_W-1:0]   axi_arid_i,
    input  logic [AXI_ADDR_W-1:0] axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
    input  logic [2:0]            axi_arsize_i,
    input  logic [1:0]            axi_arburst_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,
    output logic [AXI_ID_W-1:0]   axi_rid_o,
    output logic [AXI_DATA_W-1:0] axi_rdata_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,
    output logic                  mem_en_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    input  logic [AXI_DATA_W-1:0] mem_rdata_i
);

    state_t r_state;
    state_t w_stateNext;

    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [AXI_LEN_W-1:0]  r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_burstErr;
    logic [AXI_LEN_W:0]    r_issueCnt;
    logic                  r_inflight;
    logic                  r_inflightErr;
    logic                  r_inflightLast;

    logic                  w_arHandshake;
    logic                  w_arErr;
    logic                  w_slotFree;
    logic                  w_issue;
    logic                  w_addrOob;
    logic                  w_beatErr;
    logic                  w_beatLast;
    logic [AXI_ADDR_W-1:0] w_addrInc;
    logic [AXI_ADDR_W-1:0] w_nextAddr;
`ifdef IOB_CACHE_AXI_READ_WRAP_EN
    logic [AXI_ADDR_W-1:0] w_wrapMask;
`endif

    logic                  w_pop;
    logic                  w_fifoValid;
    logic [1:0]            w_fifoCount;
    logic [AXI_DATA_W-1:0] w_headData;
    logic [1:0]            w_headResp;
    logic                  w_headLast;

    assign axi_arready_o = reset_n_i & (r_state == IDLE);
    assign w_arHandshake = axi_arvalid_i & axi_arready_o;

    // Size mismatch (and, with wrapping, an illegal wrap length) poisons the whole burst.
`ifdef IOB_CACHE_AXI_READ_WRAP_EN
    assign w_arErr = (axi_arsize_i != 3'(NBYTES_W)) |
                     ((axi_arburst_i == BURST_WRAP) & ~wrapLenOk(32'(axi_arlen_i)));
`else
    assign w_arErr = (axi_arsize_i != 3'(NBYTES_W));
`endif

    // At most two beats may be buffered or in flight, which is exactly what the FIFO can absorb.
    assign w_slotFree = ({1'b0, w_fifoCount} + {2'b00, r_inflight}) < 3'd2;
    assign w_issue    = reset_n_i & (r_state == BURST) & (r_issueCnt <= {1'b0, r_len}) & w_slotFree;
    assign w_addrOob  = (r_addr >> (MEM_ADDR_W + NBYTES_W)) != '0;
    assign w_beatErr  = r_burstErr | w_addrOob;
    assign w_beatLast = (r_issueCnt == {1'b0, r_len});

    assign mem_en_o   = w_issue & ~w_beatErr;
    assign mem_addr_o = r_addr[MEM_ADDR_W+NBYTES_W-1:NBYTES_W];

    always_comb begin
        w_addrInc  = AXI_ADDR_W'(1) << r_size;
        w_nextAddr = r_addr + w_addrInc;
        if (r_burst == BURST_FIXED) begin
            w_nextAddr = r_addr;
        end
`ifdef IOB_CACHE_AXI_READ_WRAP_EN
        w_wrapMask = ((AXI_ADDR_W'(r_len) + AXI_ADDR_W'(1)) << r_size) - AXI_ADDR_W'(1);
        if (r_burst == BURST_WRAP) begin
            w_nextAddr = (r_addr & ~w_wrapMask) | ((r_addr + w_addrInc) & w_wrapMask);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_arHandshake) w_stateNext = BURST;
            BURST:   if (w_pop && w_headLast) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_id           <= '0;
            r_addr         <= '0;
            r_len          <= '0;
            r_size         <= '0;
            r_burst        <= '0;
            r_burstErr     <= 1'b0;
            r_issueCnt     <= '0;
            r_inflight     <= 1'b0;
            r_inflightErr  <= 1'b0;
            r_inflightLast <= 1'b0;
        end else begin
            if (w_arHandshake) begin
                r_id       <= axi_arid_i;
                r_addr     <= axi_araddr_i;
                r_len      <= axi_arlen_i;
                r_size     <= axi_arsize_i;
                r_burst    <= axi_arburst_i;
                r_burstErr <= w_arErr;
                r_issueCnt <= '0;
            end else if (w_issue) begin
                r_addr     <= w_nextAddr;
                r_issueCnt <= r_issueCnt + (AXI_LEN_W + 1)'(1);
            end
            r_inflight     <= w_issue;
            r_inflightErr  <= w_beatErr;
            r_inflightLast <= w_beatLast;
        end
    end

    iob_cache_axi_read_skid #(
        .DATA_W(AXI_DATA_W)
    ) u_skid (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_i      (r_inflight),
        .push_data_i (r_inflightErr ? '0 : mem_rdata_i),
        .push_resp_i (r_inflightErr ? RESP_SLVERR : RESP_OKAY),
        .push_last_i (r_inflightLast),
        .pop_i       (w_pop),
        .valid_o     (w_fifoValid),
        .data_o      (w_headData),
        .resp_o      (w_headResp),
        .last_o      (w_headLast),
        .count_o     (w_fifoCount)
    );

    assign axi_rvalid_o = reset_n_i & w_fifoValid;
    assign w_pop        = axi_rvalid_o & axi_rready_i;
    assign axi_rdata_o  = axi_rvalid_o ? w_headData : '0;
    assign axi_rresp_o  = axi_rvalid_o ? w_headResp : RESP_OKAY;
    assign axi_rlast_o  = axi_rvalid_o & w_headLast;
    assign axi_rid_o    = reset_n_i ? r_id : '0;

endmodule
